// File: rtl/plic_claim_complete.sv
// plic_claim_complete: target-side claim/complete responder for a 3-context PLIC.
// Builds per-context eligible vectors, answers claim reads with a sequential
// highest-priority scan, and issues claim/completion notifications.
// Optional macro PLIC_COMPLETE_CHECK_EN: forward a completion only when the
// ID is currently recorded as claimed by that context.
module plic_claim_complete #(
  parameter int INTERRUPTS    = 8,
  parameter int PRIORITY_BITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                interrupt_pending_reg,
  input  logic [32*PRIORITY_BITS-1:0] interrupt_priority,
  input  logic [95:0]                interrupt_enable,
  input  logic [3*PRIORITY_BITS-1:0] interrupt_threshold,
  input  logic                       claim_req_valid,
  input  logic [1:0]                 claim_req_ctx,
  output logic                       claim_req_ready,
  output logic                       claim_rsp_valid,
  output logic [4:0]                 claim_rsp_id,
  input  logic                       complete_valid,
  input  logic [1:0]                 complete_ctx,
  input  logic [4:0]                 complete_id,
  output logic [2:0]                 interrupt_claim_notif,
  output logic [4:0]                 interrupt_claim_ID,
  output logic [2:0]                 interrupt_completion_notif,
  output logic [31:0]                interrupt_completion_ID,
  output logic [31:0]                interrupt_active_0,
  output logic [31:0]                interrupt_active_1,
  output logic [31:0]                interrupt_active_2
);

  localparam int         NCTX = 3;
  localparam logic [4:0] LAST = 5'(INTERRUPTS);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

  logic [PRIORITY_BITS-1:0] prio [32];
  logic [31:0]              active [NCTX];

  state_t                   state;
  logic [1:0]               ctx;
  logic [31:0]              scan_vec;
  logic [4:0]               best_id;
  logic [PRIORITY_BITS-1:0] best_prio;
  logic [4:0]               idx;
  logic [NCTX-1:0][31:0]    claimed;

  logic [31:0]              req_vec;
  logic [PRIORITY_BITS-1:0] req_thr;
  logic                     cand;
  logic [4:0]               nxt_id;
  logic [PRIORITY_BITS-1:0] nxt_prio;
  logic                     claim_set;
  logic                     cmp_ok;
  logic                     cmp_fwd;

  // Unpack priorities and build the eligible vectors; ID 0 and unimplemented IDs stay 0
  genvar k, c;
  generate
    for (k = 0; k < 32; k++) begin : g_prio
      assign prio[k] = interrupt_priority[k*PRIORITY_BITS +: PRIORITY_BITS];
    end
    for (c = 0; c < NCTX; c++) begin : g_ctx
      for (k = 0; k < 32; k++) begin : g_bit
        if (k >= 1 && k <= INTERRUPTS) begin : g_on
          assign active[c][k] = interrupt_pending_reg[k] & interrupt_enable[c*32+k] &
                                (prio[k] > interrupt_threshold[c*PRIORITY_BITS +: PRIORITY_BITS]);
        end else begin : g_off
          assign active[c][k] = 1'b0;
        end
      end
    end
  endgenerate

  assign interrupt_active_0 = active[0];
  assign interrupt_active_1 = active[1];
  assign interrupt_active_2 = active[2];
  assign claim_req_ready    = (state == S_IDLE);

  // Snapshot source for a new claim; context 3 sees nothing eligible
  always_comb begin
    req_vec = '0;
    req_thr = '0;
    for (int i = 0; i < NCTX; i++) begin
      if (claim_req_ctx == 2'(i)) begin
        req_vec = active[i];
        req_thr = interrupt_threshold[i*PRIORITY_BITS +: PRIORITY_BITS];
      end
    end
  end

  // Scan step: strict compare keeps the lowest ID on equal priority
  always_comb begin
    cand      = scan_vec[idx] && (prio[idx] > best_prio);
    nxt_id    = cand ? idx : best_id;
    nxt_prio  = cand ? prio[idx] : best_prio;
    claim_set = (state == S_SCAN) && (idx == LAST) && (nxt_id != 5'd0);
  end

  // Completion qualification: in-range ID on a real context
  always_comb begin
    cmp_ok = complete_valid && (complete_id != 5'd0) && (complete_id <= LAST) &&
             (complete_ctx != 2'd3);
`ifdef PLIC_COMPLETE_CHECK_EN
    cmp_fwd = 1'b0;
    for (int i = 0; i < NCTX; i++)
      if (complete_ctx == 2'(i) && claimed[i][complete_id]) cmp_fwd = cmp_ok;
`else
    cmp_fwd = cmp_ok;
`endif
  end

`ifdef PLIC_COMPLETE_CHECK_EN
  logic unused_ok;
  assign unused_ok = ^{interrupt_pending_reg, interrupt_enable};
`else
  // claimed is tracked for visibility but not consulted in this build
  logic unused_ok;
  assign unused_ok = ^{interrupt_pending_reg, interrupt_enable, claimed};
`endif

  // Claim FSM: IDLE accepts, SCAN walks IDs 1..INTERRUPTS, RESP strobes the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      ctx                   <= '0;
      scan_vec              <= '0;
      best_id               <= '0;
      best_prio             <= '0;
      idx                   <= '0;
      claim_rsp_valid       <= 1'b0;
      claim_rsp_id          <= '0;
      interrupt_claim_notif <= '0;
      interrupt_claim_ID    <= '0;
    end else begin
      claim_rsp_valid       <= 1'b0;
      claim_rsp_id          <= '0;
      interrupt_claim_notif <= '0;
      interrupt_claim_ID    <= '0;
      case (state)
        S_IDLE: if (claim_req_valid) begin
          ctx       <= claim_req_ctx;
          scan_vec  <= req_vec;
          best_id   <= '0;
          best_prio <= req_thr;
          idx       <= 5'd1;
          state     <= S_SCAN;
        end
        S_SCAN: begin
          best_id   <= nxt_id;
          best_prio <= nxt_prio;
          idx       <= idx + 5'd1;
          if (idx == LAST) begin
            state           <= S_RESP;
            claim_rsp_valid <= 1'b1;
            claim_rsp_id    <= nxt_id;
            if (nxt_id != 5'd0) begin
              interrupt_claim_ID <= nxt_id;
              for (int i = 0; i < NCTX; i++)
                if (ctx == 2'(i)) interrupt_claim_notif[i] <= 1'b1;
            end
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion pulse and claimed tracking; the claim set is written last so it wins
  always_ff @(posedge clk) begin
    if (rst) begin
      interrupt_completion_notif <= '0;
      interrupt_completion_ID    <= '0;
      claimed                    <= '0;
    end else begin
      interrupt_completion_notif <= '0;
      interrupt_completion_ID    <= '0;
      if (cmp_fwd) begin
        interrupt_completion_ID <= {27'b0, complete_id};
        for (int i = 0; i < NCTX; i++) begin
          if (complete_ctx == 2'(i)) begin
            interrupt_completion_notif[i] <= 1'b1;
            claimed[i][complete_id]       <= 1'b0;
          end
        end
      end
      if (claim_set) begin
        for (int i = 0; i < NCTX; i++)
          if (ctx == 2'(i)) claimed[i][nxt_id] <= 1'b1;
      end
    end
  end

endmodule
